// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder in front of a fixed-latency backing word memory.
// Optional DCACHE_STATS_EN adds saturating hit/miss/store counters.
module dcache_responder #(
  parameter int ADDR_BITS   = 16,
  parameter int INDEX_BITS  = 6,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 over,
  input  logic [ADDR_BITS-1:0] rin,
  input  logic                 le,
  output logic [31:0]          rout,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          win,
  output logic                 delay
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
  output logic [31:0]          store_count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, FILL, STORE, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];
  logic [31:0]         mem  [2**ADDR_BITS];
  logic [31:0]         result;

  logic [INDEX_BITS-1:0] ridx, widx;
  logic [TAG_BITS-1:0]   rtag, wtag;
  logic rhit, whit, hit_evt, start, finish, finish_store;

  assign ridx = rin[INDEX_BITS-1:0];
  assign rtag = rin[ADDR_BITS-1:INDEX_BITS];
  assign widx = waddr[INDEX_BITS-1:0];
  assign wtag = waddr[ADDR_BITS-1:INDEX_BITS];
  assign rhit = valid[ridx] && (tags[ridx] == rtag);
  assign whit = valid[widx] && (tags[widx] == wtag);

  assign hit_evt = (state == IDLE) && !over && !we && le && rhit;
  assign start   = (state == IDLE) && !over && (we || (le && !rhit));

  // The request cycle itself counts as the first of MEM_LATENCY stall cycles,
  // so the access completes on the edge where the counter reaches zero.
  assign finish = (((state == FILL) || (state == STORE)) && (cnt == CW'(1)))
                || (start && (MEM_LATENCY == 1));
  assign finish_store = (state == IDLE) ? we : (state == STORE);

  always_comb begin
    delay = 1'b0;
    rout  = 32'd0;
    if (!reset) begin
      delay = start || (state == FILL) || (state == STORE);
      if (hit_evt)
        rout = data[ridx];
      else if (state == DONE)
        rout = result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      valid  <= '0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= CW'(MEM_LATENCY - 1);
            state <= finish ? DONE : (we ? STORE : FILL);
          end
        end
        FILL, STORE: begin
          cnt <= cnt - 1'b1;
          if (finish)
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (finish) begin
        if (finish_store) begin
          result <= 32'd0;
        end else begin
          valid[ridx] <= 1'b1;
          result      <= mem[rin];
        end
      end
    end
  end

  // Storage arrays are not reset; writes are suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (finish && !reset) begin
      if (finish_store) begin
        mem[waddr] <= win;
        if (whit)
          data[widx] <= win;
      end else begin
        tags[ridx] <= rtag;
        data[ridx] <= mem[rin];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count   <= 32'd0;
      miss_count  <= 32'd0;
      store_count <= 32'd0;
    end else begin
      if (hit_evt && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (start && !we && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
      if (start && we && (store_count != 32'hFFFF_FFFF))
        store_count <= store_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed vector table, multi-cycle corner sequences,
// and randomized loads/stores checked against a behavioural cache/memory model.
module tb_dcache_responder;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        over = 1'b0;
  logic [15:0] rin = '0;
  logic        le = 1'b0;
  logic [31:0] rout;
  logic        we = 1'b0;
  logic [15:0] waddr = '0;
  logic [31:0] win = '0;
  logic        delay;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count, store_count;
`endif

  dcache_responder #(.ADDR_BITS(16), .INDEX_BITS(6), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .over(over), .rin(rin), .le(le), .rout(rout),
    .we(we), .waddr(waddr), .win(win), .delay(delay)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .store_count(store_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: backing memory as a sparse map, cache as per-index lines.
  logic [31:0] mmem [int];
  bit          cvalid [64];
  int          ctag   [64];
  logic [31:0] cdata  [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_exec(input bit w, input bit l, input logic [15:0] a, input logic [31:0] d,
                            output int cyc, output logic [31:0] r);
    int idx, tag;
    idx = a % 64;
    tag = a / 64;
    cyc = 0;
    r   = 32'd0;
    if (w) begin
      cyc = L;
      mmem[a] = d;
      if (cvalid[idx] && ctag[idx] == tag) cdata[idx] = d;
    end else if (l) begin
      if (cvalid[idx] && ctag[idx] == tag) begin
        r = cdata[idx];
      end else begin
        cyc = L;
        r = mmem[a];
        cvalid[idx] = 1'b1;
        ctag[idx]   = tag;
        cdata[idx]  = mmem[a];
      end
    end
  endtask

  task automatic run_txn(input bit w, input bit l, input logic [15:0] a, input logic [31:0] d,
                         input int exp_cyc, input logic [31:0] exp_r, input string name);
    int cyc;
    @(negedge clk);
    we = w; le = l; rin = a; waddr = a; win = d;
    #1;
    cyc = 0;
    while (delay === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk({name, "_stall"}, cyc, exp_cyc);
    chk({name, "_rout"}, rout, exp_r);
    $display("txn %s we=%0b le=%0b addr=%h win=%h stall=%0d rout=%h", name, w, l, a, d, cyc, rout);
  endtask

  task automatic model_txn(input bit w, input bit l, input logic [15:0] a, input logic [31:0] d,
                           input string name);
    int cyc;
    logic [31:0] r;
    model_exec(w, l, a, d, cyc, r);
    run_txn(w, l, a, d, cyc, r, name);
  endtask

  typedef struct {
    bit          w;
    bit          l;
    logic [15:0] a;
    logic [31:0] d;
    int          cyc;
    logic [31:0] r;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int dc;
    logic [31:0] dr;
    int cyc;
    logic [15:0] ra;
    logic [31:0] rd;

    tbl[0] = '{1'b1, 1'b0, 16'h0010, 32'h0000_1234, L, 32'h0};           // store, no allocate
    tbl[1] = '{1'b0, 1'b1, 16'h0010, 32'h0,         L, 32'h0000_1234};   // load miss
    tbl[2] = '{1'b0, 1'b1, 16'h0010, 32'h0,         0, 32'h0000_1234};   // load hit
    tbl[3] = '{1'b1, 1'b0, 16'h0050, 32'hCAFE_F00D, L, 32'h0};           // conflict store miss
    tbl[4] = '{1'b0, 1'b1, 16'h0050, 32'h0,         L, 32'hCAFE_F00D};   // evicts 0x10
    tbl[5] = '{1'b0, 1'b1, 16'h0010, 32'h0,         L, 32'h0000_1234};   // misses again
    tbl[6] = '{1'b1, 1'b0, 16'h0010, 32'h0BAD_BEEF, L, 32'h0};           // store hit
    tbl[7] = '{1'b0, 1'b1, 16'h0010, 32'h0,         0, 32'h0BAD_BEEF};   // updated word hits
    tbl[8] = '{1'b1, 1'b1, 16'h0010, 32'h5555_AAAA, L, 32'h0};           // store wins over load
    tbl[9] = '{1'b0, 1'b1, 16'h0010, 32'h0,         0, 32'h5555_AAAA};

    // Reset state, with requests already asserted
    le = 1'b1; we = 1'b1; rin = 16'h0010; waddr = 16'h0010;
    @(negedge clk); #1;
    chk("reset_delay", {31'd0, delay}, 32'd0);
    chk("reset_rout", rout, 32'd0);
    le = 1'b0; we = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      model_exec(tbl[i].w, tbl[i].l, tbl[i].a, tbl[i].d, dc, dr);
      run_txn(tbl[i].w, tbl[i].l, tbl[i].a, tbl[i].d, tbl[i].cyc, tbl[i].r, $sformatf("tbl%0d", i));
    end

    // Reset during the second cycle of a fill
    model_txn(1'b1, 1'b0, 16'h0020, 32'h2020_AAAA, "st20");
    @(negedge clk);
    we = 1'b0; le = 1'b1; rin = 16'h0020;
    #1 chk("fill_c1_delay", {31'd0, delay}, 32'd1);
    @(negedge clk);
    #1 chk("fill_c2_delay", {31'd0, delay}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset_delay", {31'd0, delay}, 32'd0);
    chk("midreset_rout", rout, 32'd0);
    @(negedge clk);
    reset = 1'b0; le = 1'b0;
    for (int i = 0; i < 64; i++) cvalid[i] = 1'b0;
    model_txn(1'b0, 1'b1, 16'h0020, 32'h0, "ld20_after_reset");

    // over in IDLE blocks a load that would hit
    model_txn(1'b0, 1'b1, 16'h0020, 32'h0, "ld20_hit");
    @(negedge clk);
    over = 1'b1; le = 1'b1; we = 1'b0; rin = 16'h0020;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("over_delay%0d", i), {31'd0, delay}, 32'd0);
      chk($sformatf("over_rout%0d", i), rout, 32'd0);
      @(negedge clk);
    end
    over = 1'b0; le = 1'b0;

    // over rising mid-store: store still completes
    @(negedge clk);
    we = 1'b1; waddr = 16'h0030; win = 32'hABCD_0123;
    #1;
    cyc = 0;
    while (delay === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
      if (cyc == 2) over = 1'b1;
      #1;
    end
    chk("over_store_stall", cyc, L);
    chk("over_store_rout", rout, 32'd0);
    $display("txn over_store addr=0030 win=abcd0123 stall=%0d rout=%h", cyc, rout);
    model_exec(1'b1, 1'b0, 16'h0030, 32'hABCD_0123, dc, dr);
    @(negedge clk);
    over = 1'b0; we = 1'b0;
    model_txn(1'b0, 1'b1, 16'h0030, 32'h0, "ld30");

    // Randomized loads/stores over a small conflicting address pool
    for (int n = 0; n < 60; n++) begin
      ra = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 3));
      rd = $urandom;
      if (!mmem.exists(int'(ra)) || $urandom_range(0, 9) < 4)
        model_txn(1'b1, $urandom_range(0, 1) == 1, ra, rd, $sformatf("rnd%0d_st", n));
      else
        model_txn(1'b0, 1'b1, ra, 32'h0, $sformatf("rnd%0d_ld", n));
    end

    @(negedge clk);
    we = 1'b0; le = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
